// File: rtl/whr_inj_ctrl.sv
// Wormhole packet injector: serializes a header plus payload words into head/body flits with credit tracking.
// Latency: one cycle from a hdr/pld handshake to its flit on channel_out.
// Backpressure: hdr_ready/pld_ready drop while credits are exhausted. `WHR_INJ_LEN_CHECK_EN drops out-of-range headers.
module whr_inj_ctrl #(
    parameter int buffer_size          = 8,
    parameter int num_routers_per_dim  = 4,
    parameter int num_dimensions       = 2,
    parameter int num_nodes_per_router = 1,
    parameter int max_payload_length   = 4,
    parameter int min_payload_length   = 1,
    parameter int flit_data_width      = 64,
    parameter int enable_link_pm       = 1,
    localparam int addr_bits            = num_dimensions * $clog2(num_routers_per_dim)
                                        + $clog2(num_nodes_per_router),
    localparam int addr_width           = (addr_bits > 0) ? addr_bits : 1,
    localparam int length_width         = $clog2(max_payload_length + 1),
    localparam int payload_length_width = (max_payload_length > min_payload_length)
                                        ? $clog2(max_payload_length - min_payload_length + 1) : 1,
    localparam int channel_width        = flit_data_width + 2 + enable_link_pm
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       hdr_valid,
    output logic                       hdr_ready,
    input  logic [addr_width-1:0]      hdr_dest,
    input  logic [length_width-1:0]    hdr_length,
    input  logic                       pld_valid,
    output logic                       pld_ready,
    input  logic [flit_data_width-1:0] pld_data,
    output logic [channel_width-1:0]   channel_out,
    input  logic                       flow_ctrl_in,
    output logic                       busy,
    output logic                       error
);

    localparam int cred_width = $clog2(buffer_size + 1);

    typedef enum logic {IDLE, BODY} state_t;

    state_t                     state;
    logic [length_width-1:0]    rem;
    logic [cred_width-1:0]      credits;
    logic                       flit_vld_q;
    logic                       flit_head_q;
    logic [flit_data_width-1:0] flit_data_q;
    logic                       link_active_q;
    logic                       error_q;

    logic                       hdr_fire;
    logic                       pld_fire;
    logic                       len_ok;
    logic                       send_head;
    logic                       send;
    logic                       cred_avail;
    logic                       cred_full;
    logic                       cred_ret;
    logic                       overflow;
    logic [length_width-1:0]    len_diff;
    logic [flit_data_width-1:0] head_data;

`ifdef WHR_INJ_LEN_CHECK_EN
    assign len_ok = (int'(hdr_length) >= min_payload_length)
                 && (int'(hdr_length) <= max_payload_length);
`else
    assign len_ok = 1'b1;
`endif

    assign cred_avail = (credits != '0);
    assign cred_full  = (credits == cred_width'(buffer_size));
    assign hdr_ready  = (state == IDLE) && cred_avail;
    assign pld_ready  = (state == BODY) && cred_avail;
    assign hdr_fire   = hdr_valid && hdr_ready;
    assign pld_fire   = pld_valid && pld_ready;
    assign send_head  = hdr_fire && len_ok;
    assign send       = send_head || pld_fire;
    // A credit returned while the counter is already full has nowhere to go.
    assign cred_ret   = flow_ctrl_in && !cred_full;
    assign overflow   = flow_ctrl_in && cred_full;
    assign len_diff   = hdr_length - length_width'(min_payload_length);
    assign busy       = (state == BODY);
    assign error      = error_q;

    always_comb begin
        head_data = '0;
        head_data[addr_width-1:0] = hdr_dest;
        head_data[addr_width +: payload_length_width] = len_diff[payload_length_width-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rem           <= '0;
            credits       <= cred_width'(buffer_size);
            flit_vld_q    <= 1'b0;
            flit_head_q   <= 1'b0;
            flit_data_q   <= '0;
            link_active_q <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            flit_vld_q    <= send;
            flit_head_q   <= send_head;
            flit_data_q   <= send_head ? head_data : (pld_fire ? pld_data : '0);
            link_active_q <= busy || hdr_valid;
            error_q       <= overflow || (hdr_fire && !len_ok);

            if (cred_ret && !send)
                credits <= credits + cred_width'(1);
            else if (!cred_ret && send)
                credits <= credits - cred_width'(1);

            case (state)
                IDLE: begin
                    if (send_head) begin
                        rem <= hdr_length;
                        if (hdr_length != '0)
                            state <= BODY;
                    end
                end
                BODY: begin
                    if (pld_fire) begin
                        rem <= rem - length_width'(1);
                        if (rem == length_width'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    generate
        if (enable_link_pm != 0) begin : g_link_pm
            assign channel_out = {link_active_q, flit_vld_q, flit_head_q, flit_data_q};
        end else begin : g_no_link_pm
            assign channel_out = {flit_vld_q, flit_head_q, flit_data_q};
        end
    endgenerate

endmodule

// File: tb/tb_whr_inj_ctrl.sv
// Bench for whr_inj_ctrl: directed scenarios followed by random traffic against a packet-level model.
module tb_whr_inj_ctrl;

    localparam int MIN = 1;
    localparam int MAX = 4;
    localparam int BUF = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        hdr_valid;
    logic        hdr_ready, hdr_ready0;
    logic [3:0]  hdr_dest;
    logic [2:0]  hdr_length;
    logic        pld_valid;
    logic        pld_ready, pld_ready0;
    logic [63:0] pld_data;
    logic [66:0] channel_out, channel_out0;
    logic        flow_ctrl_in;
    logic        busy, busy0;
    logic        error, error0;

    int n_vec = 0;
    int n_err = 0;
    int obs_flits = 0;

    int          m_cred;
    int          m_left;
    logic [66:0] m_chan;
    logic        m_err;
    logic        m_hr, m_pr;

    always #5 clk = ~clk;

    whr_inj_ctrl u_dut (
        .clk(clk), .reset(reset),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_dest(hdr_dest), .hdr_length(hdr_length),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
        .channel_out(channel_out), .flow_ctrl_in(flow_ctrl_in), .busy(busy), .error(error)
    );

    whr_inj_ctrl #(.min_payload_length(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready0), .hdr_dest(hdr_dest), .hdr_length(hdr_length),
        .pld_valid(pld_valid), .pld_ready(pld_ready0), .pld_data(pld_data),
        .channel_out(channel_out0), .flow_ctrl_in(flow_ctrl_in), .busy(busy0), .error(error0)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: readies checked before the edge, registered outputs after it.
    task automatic step(input logic hv, input logic [3:0] hd, input logic [2:0] hl,
                        input logic pv, input logic [63:0] pd, input logic fc, input logic r);
        logic sent;
        logic la;
        logic [1:0] fld;
        hdr_valid = hv; hdr_dest = hd; hdr_length = hl;
        pld_valid = pv; pld_data = pd; flow_ctrl_in = fc; reset = r;
        @(negedge clk);
        m_hr = (m_left == 0) && (m_cred > 0);
        m_pr = (m_left > 0) && (m_cred > 0);
        check("hdr_ready", hdr_ready, m_hr);
        check("pld_ready", pld_ready, m_pr);
        la = (m_left > 0) || hv;
        if (r) begin
            m_cred = BUF; m_left = 0; m_chan = '0; m_err = 1'b0;
        end else begin
            sent = 1'b0; m_chan = '0; m_err = 1'b0;
            if (hv && m_hr) begin
`ifdef WHR_INJ_LEN_CHECK_EN
                if (int'(hl) < MIN || int'(hl) > MAX) begin
                    m_err = 1'b1;
                end else
`endif
                begin
                    sent = 1'b1;
                    fld = 2'((int'(hl) - MIN) & 3);
                    m_chan[65] = 1'b1; m_chan[64] = 1'b1;
                    m_chan[3:0] = hd; m_chan[5:4] = fld;
                    m_left = int'(hl);
                end
            end else if (pv && m_pr) begin
                sent = 1'b1;
                m_chan[65] = 1'b1; m_chan[63:0] = pd;
                m_left--;
            end
            if (fc && m_cred == BUF) m_err = 1'b1;
            m_cred = m_cred + ((fc && m_cred < BUF) ? 1 : 0) - (sent ? 1 : 0);
            m_chan[66] = la;
        end
        @(posedge clk); #1;
        check("channel_out", channel_out, m_chan);
        check("busy", busy, (m_left > 0));
        check("error", error, m_err);
        if (channel_out[65] === 1'b1) obs_flits++;
    endtask

    initial begin
        hdr_valid = 0; hdr_dest = 0; hdr_length = 0; pld_valid = 0; pld_data = 0; flow_ctrl_in = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_cred = BUF; m_left = 0; m_chan = '0; m_err = 0;
        check("rst_channel", channel_out, 67'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_hdr_ready", hdr_ready, 1'b1);
        check("rst_pld_ready", pld_ready, 1'b0);
        reset = 1'b0;

        // Basic packet: dest 5, two payload words.
        step(1, 4'd5, 3'd2, 1, 64'hA, 0, 0);
        check("t1_head", channel_out, {1'b1, 1'b1, 1'b1, 64'h15});
        step(0, 0, 0, 1, 64'hA, 0, 0);
        check("t1_bodyA", channel_out, {1'b1, 1'b1, 1'b0, 64'hA});
        step(0, 0, 0, 1, 64'hB, 0, 0);
        check("t1_bodyB", channel_out, {1'b1, 1'b1, 1'b0, 64'hB});
        check("t1_busy_done", busy, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Credit exhaustion over a back-to-back stream.
        step(0, 0, 0, 0, 0, 0, 1);
        obs_flits = 0;
        for (int i = 0; i < 12; i++) step(1, 4'd3, 3'd2, 1, 64'(100 + i), 0, 0);
        check("t2_flits8", obs_flits, 8);
        check("t2_pld_ready0", pld_ready, 1'b0);
        step(1, 4'd3, 3'd2, 1, 64'h55, 1, 0);
        check("t2_no_flit_yet", obs_flits, 8);
        step(1, 4'd3, 3'd2, 1, 64'h55, 0, 0);
        check("t2_flit9", obs_flits, 9);

        // Simultaneous send and return, then overflow at full count.
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 4'd1, 3'd2, 0, 0, 0, 0);
        step(0, 0, 0, 1, 64'h1, 1, 0);
        step(0, 0, 0, 1, 64'h2, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t3_no_err_at_fill", error, 1'b0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t3_overflow_err", error, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t3_err_one_cycle", error, 1'b0);

        // Zero-length packets on the min=0 instance.
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 4'd3, 3'd0, 0, 0, 0, 0);
        check("t4_head0", channel_out0, {1'b1, 1'b1, 1'b1, 64'h3});
        check("t4_busy0", busy0, 1'b0);
        check("t4_hdr_ready0", hdr_ready0, 1'b1);
        step(1, 4'd7, 3'd0, 0, 0, 0, 0);
        check("t4_head1", channel_out0, {1'b1, 1'b1, 1'b1, 64'h7});

        // Reset in the middle of a body.
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 4'd2, 3'd3, 0, 0, 0, 0);
        step(0, 0, 0, 1, 64'hC0, 0, 0);
        step(0, 0, 0, 1, 64'hC1, 0, 1);
        check("t5_chan_zero", channel_out, 67'd0);
        check("t5_idle", busy, 1'b0);
        step(1, 4'd9, 3'd1, 0, 0, 0, 0);
        check("t5_new_head", channel_out, {1'b1, 1'b1, 1'b1, 64'h9});
        step(0, 0, 0, 1, 64'hD0, 0, 0);
        check("t5_new_body", channel_out, {1'b1, 1'b1, 1'b0, 64'hD0});

        // Length above max.
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 4'd2, 3'd5, 0, 0, 0, 0);
`ifdef WHR_INJ_LEN_CHECK_EN
        check("t6_dropped", channel_out[65], 1'b0);
        check("t6_err", error, 1'b1);
`else
        check("t6_head", channel_out, {1'b1, 1'b1, 1'b1, 64'h2});
        obs_flits = 0;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 64'(200 + i), 0, 0);
        check("t6_five_bodies", obs_flits, 5);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 1) == 1), 4'($urandom), 3'($urandom_range(0, 5)),
                 ($urandom_range(0, 9) < 7), {$urandom, $urandom},
                 ($urandom_range(0, 99) < 35), ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
